// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter family: widths, FSM state codes and grant codes.
// The TLB-refill walker will join as a third requester using the same package.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned WDOG_W   = 8;
    localparam int unsigned GRANT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic [GRANT_W-1:0] GRANT_NONE = 2'b00;
    localparam logic [GRANT_W-1:0] GRANT_I    = 2'b01;
    localparam logic [GRANT_W-1:0] GRANT_D    = 2'b10;

    // Owner code visible on the grant port for a given arbiter state.
    function automatic logic [GRANT_W-1:0] grant_of(input arb_state_e st);
        logic [GRANT_W-1:0] g;
        g = GRANT_NONE;
        case (st)
            ST_GNT_I: g = GRANT_I;
            ST_GNT_D: g = GRANT_D;
            default:  g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Grant watchdog: counts grant cycles without a memory answer, flags expiry and
// keeps a sticky error until reset.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic clrn,
    input  logic run,
    input  logic hit,
    output logic expire,
    output logic err
);

    logic [WDOG_W-1:0] r_cnt;
    logic              r_err;

    // Expiry fires on the cycle whose miss would bring the count to TIMEOUT; a hit wins.
    assign expire = run && !hit && (r_cnt == WDOG_W'(TIMEOUT - 1));
    assign err    = r_err;

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!run || hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + WDOG_W'(1);
            end
            if (expire) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: D-cache priority with a bounded streak so
// I-fetch cannot starve, one bubble cycle between transactions, grant watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [ADDR_W-1:0]  i_a,
    input  logic               i_strobe,
    output logic [DATA_W-1:0]  i_dout,
    output logic               i_ready,
    input  logic [ADDR_W-1:0]  d_a,
    input  logic [DATA_W-1:0]  d_din,
    input  logic               d_strobe,
    input  logic               d_rw,
    output logic [DATA_W-1:0]  d_dout,
    output logic               d_ready,
    output logic [ADDR_W-1:0]  m_a,
    output logic [DATA_W-1:0]  m_din,
    output logic               m_strobe,
    output logic               m_rw,
    input  logic [DATA_W-1:0]  m_dout,
    input  logic               m_ready,
    output logic [GRANT_W-1:0] grant,
    output logic               err
);

    arb_state_e          r_state;
    arb_state_e          w_next;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_next;
    logic                w_run;
    logic                w_expire;
    logic                w_err;
    logic                w_d_wins;

    assign w_run    = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);
    assign w_d_wins = d_strobe && (!i_strobe || (r_streak < STREAK_W'(MAX_D_STREAK)));
    assign i_dout   = m_dout;
    assign d_dout   = m_dout;
    assign err      = w_err;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .clrn   (clrn),
        .run    (w_run),
        .hit    (m_ready),
        .expire (w_expire),
        .err    (w_err)
    );

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_next;
        end
    end

    // Arbitration, streak bookkeeping and memory-bus steering.
    always_comb begin
        w_next        = r_state;
        w_streak_next = r_streak;
        m_strobe      = 1'b0;
        m_rw          = 1'b0;
        m_a           = '0;
        m_din         = '0;
        i_ready       = 1'b0;
        d_ready       = 1'b0;
        grant         = grant_of(r_state);

        case (r_state)
            ST_IDLE: begin
                if (!i_strobe) begin
                    w_streak_next = '0;
                end
                if (w_d_wins) begin
                    w_next = ST_GNT_D;
                    if (i_strobe && (r_streak != '1)) begin
                        w_streak_next = r_streak + STREAK_W'(1);
                    end
                end else if (i_strobe) begin
                    w_next        = ST_GNT_I;
                    w_streak_next = '0;
                end
            end
            ST_GNT_I: begin
                m_strobe = 1'b1;
                m_a      = i_a;
                if (m_ready) begin
                    i_ready = 1'b1;
                    w_next  = ST_DONE;
                end else if (w_expire) begin
                    w_next = ST_DONE;
                end
            end
            ST_GNT_D: begin
                m_strobe = 1'b1;
                m_a      = d_a;
                m_rw     = d_rw;
                m_din    = d_din;
                if (m_ready) begin
                    d_ready = 1'b1;
                    w_next  = ST_DONE;
                end else if (w_expire) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single external memory port between the instruction cache and the write-through data cache of the pipelined CPU. It sits between the caches' memory-side buses and the memory, serialises their transactions, and routes `m_ready`/`m_dout` back to the granted side. The data side has priority, bounded by a streak limit so instruction fetch cannot starve. A watchdog flags a memory that never answers.

## Interface
Parameters:
- `MAX_D_STREAK`, 4: maximum consecutive D grants while I is pending; range 1..15.
- `TIMEOUT`, 255: cycles a grant may wait for `m_ready` before abort; range 1..255.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `clrn`  in  1  reset; synchronous, active-high.
- `i_a`  in  32  I-side address.
- `i_strobe`  in  1  I-side request; read-only.
- `i_dout`  out  32  read data to I side.
- `i_ready`  out  1  I transaction complete.
- `d_a`  in  32  D-side address.
- `d_din`  in  32  D-side write data.
- `d_strobe`  in  1  D-side request.
- `d_rw`  in  1  D-side direction: 1 is write, 0 is read.
- `d_dout`  out  32  read data to D side.
- `d_ready`  out  1  D transaction complete.
- `m_a`  out  32  memory address.
- `m_din`  out  32  memory write data.
- `m_strobe`  out  1  memory request.
- `m_rw`  out  1  memory direction.
- `m_dout`  in  32  memory read data.
- `m_ready`  in  1  memory done.
- `grant`  out  2  current owner: 00 none, 01 I, 10 D.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, GNT_I, GNT_D, DONE.
- **IDLE.** If `d_strobe` and either `!i_strobe` or `streak < MAX_D_STREAK`, go to GNT_D. Otherwise, if `i_strobe`, go to GNT_I. Otherwise stay in IDLE.
- **Streak counter (4 bits).** On an IDLE→GNT_D transition with `i_strobe` high, increment, saturating at 15. On IDLE→GNT_I, or on any IDLE cycle with `i_strobe` low, clear to 0.
- **GNT_x, bus drive.** `m_strobe` is 1. `m_a` comes from the granted side. `m_rw` is `d_rw` for D and 0 for I. `m_din` is `d_din` for D and 0 for I.
- **GNT_x, completion.** When `m_ready` is 1, assert the granted side's `x_ready` combinationally in the same cycle and go to DONE. The ungranted side's ready is always 0.
- **Read data.** `i_dout` and `d_dout` are both wired directly to `m_dout`; only the matching ready qualifies them.
- **DONE.** One bubble cycle with `m_strobe` 0, then IDLE. The bubble lets the requester drop or re-assert its strobe.
- **Requester protocol.** A requester holds its strobe, address and data stable until its ready.
  - If a strobe drops during GNT, the arbiter keeps driving the latched owner and waits for `m_ready`. The memory transaction is already committed.
- **Watchdog.** An 8-bit counter clears on entry to GNT and increments each GNT cycle without `m_ready`.
  - When it reaches `TIMEOUT`: set `err`, force DONE, and deassert `m_strobe`. No ready is issued.
  - `err` clears only on reset.
- **Outputs in IDLE and DONE.** `m_strobe`, `m_rw` and both readies are 0. `m_a` and `m_din` are 0.

## Timing
- **Reset.** While `clrn` is 1 at the edge: state is IDLE, streak 0, watchdog 0, `err` 0. All outputs are 0, including `grant` 00.
- **Reset mid-GNT.** The transaction is abandoned and `m_strobe` drops on the next cycle.
- **Latency.** A strobe high in IDLE at edge N gives `m_strobe` high in cycle N+1. With `m_ready` at cycle N+1+k, the requester sees ready in that same cycle.
- **Throughput.** Back-to-back same-side transactions cost at least 3 cycles each: GNT, DONE, IDLE.
- **Simultaneous strobes in IDLE.** D wins unless the streak is at the limit.
- **`m_ready` on the first GNT cycle.** This is legal and gives a 1-cycle transaction.
- **Watchdog vs. `m_ready`.** If `m_ready` arrives in the same cycle the watchdog hits `TIMEOUT`, `m_ready` wins: ready is issued and `err` stays 0.
- **`m_ready` outside GNT.** Ignored.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, DONE=2'd3;
  - the grant codes.
- The package is reused by the TLB-refill walker, which will become a third requester later.
- Sub-module `arb_watchdog` contains the counter, compare and sticky `err`, with inputs `clk`, `clrn`, `run`, `hit` and outputs `expire`, `err`.
- Everything else lives in a single module.

## Test plan
- **Single D write.** `d_strobe=1`, `d_rw=1`, `d_a=0x100`, `d_din=0xDEADBEEF`; memory readies after 3 cycles. Expect `m_strobe` from cycle 1, `m_a=0x100`, `m_rw=1`, `d_ready` pulse in cycle 4, `i_ready` 0 throughout.
- **Simultaneous requests, streak.** Both strobes held continuously with `MAX_D_STREAK=4`. Expect the grant sequence D,D,D,D,I,D,D,D,D,I.
- **I read.** `i_a=0x400`, `m_dout=0x12345678` at `m_ready`. Expect `i_dout=0x12345678` with `i_ready`, and `m_rw=0`.
- **Timeout.** `TIMEOUT=8`, `m_ready` never asserted. Expect `err=1` after 8 GNT cycles, `m_strobe` 0 in the next cycle, no ready, and the next request still served.
- **Reset mid-transaction.** Pulse `clrn` during GNT_D. Expect all outputs 0 on the next cycle, `grant=00`, streak 0.
- **Edge cases.** `m_ready` on the first GNT cycle gives a 1-cycle transaction. `d_strobe` dropped mid-GNT: the arbiter still completes on `m_ready`.
